// File: rtl/alarm_clock_pkg.sv
// Shared types and helpers for the multi-alarm clock core.
// Shared by the hms counter, the alarm bank and the ring FSM.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;
    localparam int SEC_PER_MIN   = 60;

    typedef struct packed {
        logic       en;
        logic [4:0] hour;
        logic [5:0] min;
    } alarm_slot_t;

    function automatic logic [7:0] bin2bcd2(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 6'd10);
        u = 4'(v % 6'd10);
        return {t, u};
    endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Configuration bus of the alarm clock: time-set request and alarm-slot writes.
// The host side drives it through master; the clock core listens on slave.
interface multi_alarm_clock_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic          set_time;
    logic [4:0]    set_hour;
    logic [5:0]    set_min;
    logic          alm_we;
    logic [IW-1:0] alm_idx;
    logic [4:0]    alm_hour;
    logic [5:0]    alm_min;
    logic          alm_en;

    modport master (
        output set_time, set_hour, set_min,
        output alm_we, alm_idx, alm_hour, alm_min, alm_en
    );

    modport slave (
        input set_time, set_hour, set_min,
        input alm_we, alm_idx, alm_hour, alm_min, alm_en
    );

endinterface

// File: rtl/multi_alarm_clock_hms.sv
// hh:mm:ss counter driven by a 1 Hz tick, with validated time-set load.
// roll pulses alongside the first cycle of each new minute.
module hms_counter
    import alarm_clock_pkg::*;
#(
    parameter int INIT_HOUR = 7,
    parameter int INIT_MIN  = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_time,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       roll
);

    logic set_ok;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign set_ok = set_time
                 && (32'(set_hour) < HOURS_PER_DAY)
                 && (32'(set_min) < MIN_PER_HOUR);

    assign sec_wrap  = (32'(sec) == SEC_PER_MIN - 1);
    assign min_wrap  = (32'(min) == MIN_PER_HOUR - 1);
    assign hour_wrap = (32'(hour) == HOURS_PER_DAY - 1);

    // A valid set swallows a coincident tick; an invalid one lets it through.
    always_ff @(posedge clk) begin
        if (rst) begin
            hour <= 5'(INIT_HOUR);
            min  <= 6'(INIT_MIN);
            sec  <= '0;
            roll <= 1'b0;
        end else begin
            roll <= 1'b0;
            if (set_ok) begin
                hour <= set_hour;
                min  <= set_min;
                sec  <= '0;
            end else if (tick) begin
                if (sec_wrap) begin
                    sec  <= '0;
                    roll <= 1'b1;
                    if (min_wrap) begin
                        min  <= '0;
                        hour <= hour_wrap ? 5'd0 : hour + 5'd1;
                    end else begin
                        min <= min + 6'd1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// Multi-alarm clock: hms counter, NUM_ALARMS slots and one ring/snooze FSM.
// Define TWELVE_HOUR_EN for 12-hour bcd hour digits and a live pm flag.
module multi_alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter  int NUM_ALARMS     = 4,
    parameter  int INIT_HOUR      = 7,
    parameter  int INIT_MIN       = 29,
    parameter  int SNOOZE_MIN     = 5,
    parameter  int RING_TIMEOUT_S = 60,
    parameter  int MAX_SNOOZE     = 3,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    multi_alarm_clock_if.slave  cfg,
    input  logic                btn_snooze,
    input  logic                btn_stop,
    output logic [4:0]          hour,
    output logic [5:0]          min,
    output logic [5:0]          sec,
    output logic [15:0]         bcd,
    output logic                pm,
    output logic                ring,
    output logic [IW-1:0]       ring_idx,
    output logic [1:0]          state
);

    localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * SEC_PER_MIN);

    logic          roll;
    alarm_slot_t   slots [NUM_ALARMS];
    logic          alm_ok;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          match;
    logic [IW-1:0] match_idx;

    alarm_state_t  st;
    logic [7:0]    ring_tmr;
    logic [2:0]    snooze_cnt;
    logic [11:0]   countdown;
    logic          snooze_ok;
    logic          timeout;

    hms_counter #(
        .INIT_HOUR (INIT_HOUR),
        .INIT_MIN  (INIT_MIN)
    ) u_hms (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .set_time (cfg.set_time),
        .set_hour (cfg.set_hour),
        .set_min  (cfg.set_min),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .roll     (roll)
    );

    assign alm_ok = cfg.alm_we
                 && (32'(cfg.alm_idx) < NUM_ALARMS)
                 && (32'(cfg.alm_hour) < HOURS_PER_DAY)
                 && (32'(cfg.alm_min) < MIN_PER_HOUR);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slots[i] <= '0;
            end
        end else if (alm_ok) begin
            slots[cfg.alm_idx] <= '{en:   cfg.alm_en,
                                    hour: cfg.alm_hour,
                                    min:  cfg.alm_min};
        end
    end

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slots[i].en && slots[i].hour == hour
                && slots[i].min == min) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match     <= 1'b0;
            match_idx <= '0;
        end else begin
            match     <= roll && hit;
            match_idx <= hit_idx;
        end
    end

    assign snooze_ok = (32'(snooze_cnt) < MAX_SNOOZE);
    assign timeout   = (32'(ring_tmr) + 1 == RING_TIMEOUT_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            ring       <= 1'b0;
            ring_idx   <= '0;
            ring_tmr   <= '0;
            snooze_cnt <= '0;
            countdown  <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (match) begin
                        st         <= RING;
                        ring       <= 1'b1;
                        ring_idx   <= match_idx;
                        ring_tmr   <= '0;
                        snooze_cnt <= '0;
                    end
                end
                RING: begin
                    if (btn_stop) begin
                        st   <= IDLE;
                        ring <= 1'b0;
                    end else if (btn_snooze && snooze_ok) begin
                        st         <= SNOOZE;
                        ring       <= 1'b0;
                        countdown  <= SNOOZE_LOAD;
                        snooze_cnt <= snooze_cnt + 3'd1;
                    end else if (tick) begin
                        if (timeout) begin
                            st   <= IDLE;
                            ring <= 1'b0;
                        end else begin
                            ring_tmr <= ring_tmr + 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (btn_stop) begin
                        st <= IDLE;
                    end else if (match) begin
                        st         <= RING;
                        ring       <= 1'b1;
                        ring_idx   <= match_idx;
                        ring_tmr   <= '0;
                        snooze_cnt <= '0;
                    end else if (tick) begin
                        if (countdown == 12'd1) begin
                            st        <= RING;
                            ring      <= 1'b1;
                            ring_tmr  <= '0;
                            countdown <= '0;
                        end else begin
                            countdown <= countdown - 12'd1;
                        end
                    end
                end
                default: begin
                    st   <= IDLE;
                    ring <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

    logic [5:0] disp_hour;

`ifdef TWELVE_HOUR_EN
    always_comb begin
        disp_hour = {1'b0, hour};
        if (hour == 5'd0) begin
            disp_hour = 6'd12;
        end else if (hour > 5'd12) begin
            disp_hour = {1'b0, hour - 5'd12};
        end
    end
    assign pm = (hour >= 5'd12);
`else
    assign disp_hour = {1'b0, hour};
    assign pm        = 1'b0;
`endif

    assign bcd = {bin2bcd2(disp_hour), bin2bcd2(min)};

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: table of time vectors plus
// hand-written alarm, snooze, timeout and reset sequences.
module tb_multi_alarm_clock;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        btn_snooze = 1'b0;
    logic        btn_stop = 1'b0;
    logic [4:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic [15:0] bcd;
    logic        pm;
    logic        ring;
    logic [1:0]  ring_idx;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;

    multi_alarm_clock_if #(.NUM_ALARMS(4)) cfg ();

    multi_alarm_clock #(.NUM_ALARMS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .cfg        (cfg.slave),
        .btn_snooze (btn_snooze),
        .btn_stop   (btn_stop),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .bcd        (bcd),
        .pm         (pm),
        .ring       (ring),
        .ring_idx   (ring_idx),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            cyc();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic set_t(input int h, input int m);
        cfg.set_hour = 5'(h);
        cfg.set_min  = 6'(m);
        cfg.set_time = 1'b1;
        cyc();
        cfg.set_time = 1'b0;
        cyc();
    endtask

    task automatic wr_slot(input int idx, input int h, input int m,
                           input bit en);
        cfg.alm_idx  = 2'(idx);
        cfg.alm_hour = 5'(h);
        cfg.alm_min  = 6'(m);
        cfg.alm_en   = en;
        cfg.alm_we   = 1'b1;
        cyc();
        cfg.alm_we   = 1'b0;
        cyc();
    endtask

    task automatic press(input bit stop, input bit snz);
        btn_stop   = stop;
        btn_snooze = snz;
        cyc();
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
    endtask

    typedef struct {
        bit          do_set;
        int          sh;
        int          sm;
        int          nt;
        int          eh;
        int          em;
        int          es;
        logic [15:0] bcd24;
        logic [15:0] bcd12;
        bit          pm12;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{0,  0,  0,  0,  7, 29,  0, 16'h0729, 16'h0729, 0};
        vecs[1] = '{0,  0,  0, 59,  7, 29, 59, 16'h0729, 16'h0729, 0};
        vecs[2] = '{0,  0,  0,  1,  7, 30,  0, 16'h0730, 16'h0730, 0};
        vecs[3] = '{1, 23, 59,  0, 23, 59,  0, 16'h2359, 16'h1159, 1};
        vecs[4] = '{0,  0,  0, 60,  0,  0,  0, 16'h0000, 16'h1200, 0};
        vecs[5] = '{1, 24, 10,  0,  0,  0,  0, 16'h0000, 16'h1200, 0};
        vecs[6] = '{1, 12, 60,  0,  0,  0,  0, 16'h0000, 16'h1200, 0};
        vecs[7] = '{1, 12, 34,  5, 12, 34,  5, 16'h1234, 16'h1234, 1};
        vecs[8] = '{1,  9,  5,  0,  9,  5,  0, 16'h0905, 16'h0905, 0};

        cfg.set_time = 1'b0;
        cfg.set_hour = '0;
        cfg.set_min  = '0;
        cfg.alm_we   = 1'b0;
        cfg.alm_idx  = '0;
        cfg.alm_hour = '0;
        cfg.alm_min  = '0;
        cfg.alm_en   = 1'b0;

        do_reset();
        check("rst.state", state, 0);
        check("rst.ring", ring, 0);
        check("rst.ring_idx", ring_idx, 0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_set) set_t(vecs[i].sh, vecs[i].sm);
            tick_n(vecs[i].nt);
            check($sformatf("v%0d.hour", i), hour, vecs[i].eh);
            check($sformatf("v%0d.min", i), min, vecs[i].em);
            check($sformatf("v%0d.sec", i), sec, vecs[i].es);
`ifdef TWELVE_HOUR_EN
            check($sformatf("v%0d.bcd", i), bcd, vecs[i].bcd12);
            check($sformatf("v%0d.pm", i), pm, vecs[i].pm12);
`else
            check($sformatf("v%0d.bcd", i), bcd, vecs[i].bcd24);
            check($sformatf("v%0d.pm", i), pm, 0);
`endif
            check($sformatf("v%0d.state", i), state, 0);
        end

        // slot0 at 07:30: tick -> time, +1 match, +1 ring
        do_reset();
        wr_slot(0, 7, 30, 1);
        tick_n(59);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("lat.min", min, 30);
        check("lat.sec", sec, 0);
        check("lat.ring0", ring, 0);
        cyc();
        check("lat.ring1", ring, 0);
        cyc();
        check("lat.ring2", ring, 1);
        check("lat.state", state, 1);
        check("lat.idx", ring_idx, 0);
        press(1, 0);
        check("stop.state", state, 0);
        check("stop.ring", ring, 0);

        // lowest enabled matching slot wins; stop beats snooze
        do_reset();
        wr_slot(0, 7, 30, 0);
        wr_slot(1, 7, 30, 1);
        wr_slot(2, 7, 31, 1);
        wr_slot(3, 7, 30, 1);
        tick_n(60);
        check("prio.ring", ring, 1);
        check("prio.idx", ring_idx, 1);
        press(1, 1);
        check("both.state", state, 0);
        check("both.ring", ring, 0);

        // snooze three times, fourth ignored, then ring timeout
        do_reset();
        wr_slot(2, 7, 30, 1);
        tick_n(60);
        check("snz.ring", ring, 1);
        check("snz.idx", ring_idx, 2);
        for (int k = 1; k <= 3; k++) begin
            press(0, 1);
            check($sformatf("snz%0d.state", k), state, 2);
            check($sformatf("snz%0d.ring", k), ring, 0);
            tick_n(299);
            check($sformatf("snz%0d.wait", k), state, 2);
            tick_n(1);
            check($sformatf("snz%0d.back", k), state, 1);
            check($sformatf("snz%0d.rring", k), ring, 1);
            check($sformatf("snz%0d.idx", k), ring_idx, 2);
        end
        press(0, 1);
        check("snz4.state", state, 1);
        tick_n(59);
        check("tmo.before", state, 1);
        tick_n(1);
        check("tmo.state", state, 0);
        check("tmo.ring", ring, 0);

        // reset in the middle of a snooze
        do_reset();
        wr_slot(0, 7, 30, 1);
        tick_n(60);
        press(0, 1);
        check("rs.snz", state, 2);
        tick_n(10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rs.state", state, 0);
        check("rs.ring", ring, 0);
        check("rs.hour", hour, 7);
        check("rs.min", min, 29);
        check("rs.sec", sec, 0);
        tick_n(62);
        check("rs.noslot", state, 0);
        check("rs.noring", ring, 0);

        // set_time wins over a coincident tick
        cfg.set_hour = 5'd23;
        cfg.set_min  = 6'd59;
        cfg.set_time = 1'b1;
        tick = 1'b1;
        cyc();
        cfg.set_time = 1'b0;
        tick = 1'b0;
        check("co.hour", hour, 23);
        check("co.min", min, 59);
        check("co.sec", sec, 0);
        tick_n(60);
        check("wrap.hour", hour, 0);
        check("wrap.min", min, 0);
        check("wrap.sec", sec, 0);

        // set_time onto an alarm time never rings
        wr_slot(1, 8, 0, 1);
        set_t(8, 0);
        cyc();
        cyc();
        cyc();
        check("setal.hour", hour, 8);
        check("setal.state", state, 0);
        check("setal.ring", ring, 0);

        set_t(13, 5);
`ifdef TWELVE_HOUR_EN
        check("h12.bcd", bcd, 16'h0105);
        check("h12.pm", pm, 1);
`else
        check("h24.bcd", bcd, 16'h1305);
        check("h24.pm", pm, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor of the single-alarm clock core. Keeps hh:mm:ss time from an external 1 Hz tick and supports runtime time-setting. Holds NUM_ALARMS independently programmable alarms and runs one shared ring/snooze/dismiss FSM with a ring timeout and a snooze limit. Sits between the tick prescaler and the 7-segment driver: BCD digits go to seg7, ring goes to an LED/buzzer.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..16)
INIT_HOUR, 7, hour loaded at reset (0..23)
INIT_MIN, 29, minute loaded at reset (0..59)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_TIMEOUT_S, 60, seconds of ringing before auto-dismiss (1..255)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle pulse, once per second
set_time  in  1  one-cycle request to load set_hour:set_min
set_hour  in  5  new hour
set_min  in  6  new minute
alm_we  in  1  one-cycle alarm-slot write strobe
alm_idx  in  $clog2(NUM_ALARMS) (min 1)  slot written
alm_hour  in  5  alarm hour
alm_min  in  6  alarm minute
alm_en  in  1  slot enable
btn_snooze  in  1  debounced one-cycle pulse
btn_stop  in  1  debounced one-cycle pulse
hour  out  5  binary hour 0..23
min  out  6  binary minute
sec  out  6  binary second
bcd  out  16  {Ht,Hu,Mt,Mu}
pm  out  1  PM flag (12-h mode only)
ring  out  1  alarm sounding
ring_idx  out  $clog2(NUM_ALARMS)  slot that caused the current event
state  out  2  FSM state (0 IDLE, 1 RING, 2 SNOOZE)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: time = INIT_HOUR:INIT_MIN:00. All slots are 0:00 and disabled. State is IDLE. ring=0, ring_idx=0, pm per mode. Snooze and ring counters are 0.
- Time: on tick, sec increments. sec 59→0 carries into min, min 59→0 carries into hour, 23:59:59→00:00:00. Outputs are registered and update the cycle after tick.
- set_time: loads set_hour:set_min and sets sec=0. It has priority over a same-cycle tick, which is dropped. A request with hour>23 or min>59 is ignored entirely.
- alm_we: writes the slot the next cycle. Invalid hour/min is ignored. alm_idx≥NUM_ALARMS is ignored.
- Match: evaluated only on a tick that rolls sec 59→0, against the new hh:mm. A match pulse fires in the following cycle. set_time never triggers a match. If several enabled slots match, the lowest index wins.
- FSM:
  - IDLE: on match → RING. Latch ring_idx, clear the ring timer, clear the snooze count.
  - RING: ring=1 and the ring timer counts ticks.
    - btn_stop → IDLE.
    - btn_snooze with snooze count<MAX_SNOOZE → SNOOZE. Load countdown = SNOOZE_MIN*60 and increment snooze count.
    - btn_snooze at the limit is ignored.
    - Ring timer reaching RING_TIMEOUT_S → IDLE.
    - A match while in RING is ignored.
  - SNOOZE: ring=0 and the countdown decrements per tick.
    - Countdown reaching 0 → RING with the timer cleared; ring_idx is kept.
    - btn_stop → IDLE.
    - A new match → RING with the new ring_idx and the snooze count cleared.
- btn_stop and btn_snooze in the same cycle: stop wins.
- Rewriting or disabling the ringing slot does not stop the current event.
- rst mid-ring or mid-snooze: returns to IDLE immediately. Alarm slots are cleared.
- ring and state are registered and change the cycle after the causing event.

Optional Feature:
TWELVE_HOUR_EN:
- Defined: bcd hour digits show 12-hour format (0→12, 13→1, etc.). pm=1 for hours 12..23. Internal hour remains 0..23, and alarm and set inputs stay 24-h.
- Undefined: bcd shows 24-h hours and pm is tied to 0.

Decomposition:
- Package alarm_clock_pkg:
  - alarm_state_t enum {IDLE, RING, SNOOZE}
  - constants HOURS_PER_DAY=24, MIN_PER_HOUR=60, SEC_PER_MIN=60
  - function bin2bcd2 (6-bit value → two BCD digits)
  - alarm slot struct {en, hour, min}
- Sub-module hms_counter: the sec/min/hour counter with set_time load and the rollover strobe output.
- The alarm bank and FSM stay in multi_alarm_clock.

Test Plan:
- Reset, then 60 ticks → time 07:30:00 and bcd=16'h0730. With slot0 = 07:30 enabled, ring=1 and ring_idx=0 one cycle after the match pulse.
- Slots 1 and 3 both set to 07:30 and enabled → ring_idx=1. btn_stop and btn_snooze in the same cycle → IDLE.
- Ringing, btn_snooze → SNOOZE. After 300 ticks → RING again. Repeat up to MAX_SNOOZE=3; the 4th btn_snooze is ignored and the state stays RING.
- Ringing with no buttons → after 60 ticks state=IDLE and ring=0.
- set_time 23:59 coincident with a tick, then 60 ticks → 00:00:00. set_time 24:10 → ignored. set_time exactly onto an alarm time → no ring.
- rst asserted while in SNOOZE → IDLE, time 07:29:00, all slots disabled. With TWELVE_HOUR_EN, set 13:05 → bcd=16'h0105 and pm=1.
